pic_ctrl: RTL
=============

Name: pic_ctrl

Overview:
Eight-input interrupt controller that sits directly upstream of the CPU core's interrupt inputs (irq toggle, irq_in vector).
- Latches single-cycle request pulses from the timer, keyboard, vretrace and other sources.
- Applies a mask and selects by fixed priority.
- Delivers one interrupt at a time as a toggle plus vector byte, and waits for EOI before delivering the next.
- Decodes its own I/O ports from the core's port bus.

Parameters:
VBASE, 8'h08, vector number for input 0; input k yields VBASE+k
PORT_CMD, 16'h0020, command/EOI/status port address
PORT_MASK, 16'h00A0, mask register port address

Ports:
clock  in  1  system clock (25 MHz domain)
reset_n  in  1  synchronous, active-low reset
irq_req  in  8  request pulses, 1 cycle each; bit 0 highest priority
port_a  in  16  core port address
port_w  in  1  core port write strobe (1 cycle)
port_r  in  1  core port read strobe (1 cycle)
port_o  in  8  core port write data
port_i  out  8  read data, registered
port_hit  out  1  1 for the cycle port_i holds data from this block
irq  out  1  toggles once per delivered interrupt
irq_vec  out  8  vector of the last delivered interrupt
in_service  out  1  1 from delivery until EOI
isr_num  out  3  index of the interrupt in service

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous, active-low on `reset_n`, sampled at the posedge.
- Reset values: irr=0, mask=8'h00 (all enabled), in_service=0, isr_num=0, irq=0, irq_vec=0, port_i=0, port_hit=0.
- Reset mid-operation drops all pending and in-service state. irq returns to 0; the core must be reset together with this block.
- IRR:
  - irr[k] is set at the posedge where irq_req[k]=1.
  - Repeated pulses while the bit is already set collapse into one; no counting.
  - Masked inputs still latch in irr.
- Eligible set: eligible = irr & ~mask, using register values.
- Dispatch condition: at a posedge with in_service=0 and eligible != 0, select k = the lowest set index of eligible, then:
  - irq <= ~irq;
  - irq_vec <= VBASE + k (8-bit wrap);
  - isr_num <= k;
  - in_service <= 1;
  - irr[k] <= 0.
- Dispatch latency: a request pulse at edge N sets irr at N. Dispatch happens at edge N+1, so irq flips 2 edges after the pulse was presented.
- Same-bit collision: if irq_req[k]=1 at the same edge irr[k] is cleared by dispatch, the set wins. irr[k] stays 1 and is delivered again after EOI.
- No nesting:
  - While in_service=1, nothing is delivered regardless of priority.
  - A higher-priority request simply waits in irr.
- Command writes (port_w && port_a==PORT_CMD):
  - 8'h20 = EOI: in_service <= 0. No effect if already 0.
  - 8'h40 = clear all irr. A same-edge irq_req bit still sets, because set wins.
  - Any other value is ignored.
- EOI vs dispatch: dispatch uses the registered in_service. After an EOI at edge E, the earliest next dispatch is edge E+1.
- Mask write (port_w && port_a==PORT_MASK): mask <= port_o. A 1 disables that input. The new mask takes effect for the dispatch decision at the next edge.
- Unmasking: a masked irr bit is delivered as soon as it is unmasked and in_service=0.
- Masking while in service: masking the in-service input does not end service; only EOI does.
- Reads (port_r):
  - PORT_CMD: port_i <= irr, port_hit <= 1.
  - PORT_MASK: port_i <= mask, port_hit <= 1.
  - Any other address: port_hit <= 0 and port_i holds.
  - port_hit is 0 in every cycle without a matching read.
  - Reads have no side effects.
- Write/read collision: a simultaneous port_w and port_r to the same port returns the pre-write value.
- Other addresses: writes to addresses other than the two ports are ignored.

Test Plan:
- Reset, then a 1-cycle irq_req=8'h02 -> irq goes 0→1 two edges later; irq_vec=8'h09, isr_num=1, in_service=1; a PORT_CMD read returns 8'h00.
- irq_req=8'h05 in one cycle -> vector 8'h08 delivered first. irr reads 8'h04. No second toggle until a write of 8'h20 to PORT_CMD; then irq toggles back and irq_vec=8'h0A one edge later.
- Mask write 8'h01, then irq_req=8'h01 -> no toggle for 100 cycles, and a PORT_CMD read returns 8'h01. Writing mask 8'h00 -> delivery with irq_vec=8'h08 on the following edge.
- While in service for input 2, pulse irq_req[2] at the same edge as the EOI write -> exactly one further delivery of 8'h0A, then irr=0.
- Pulse irq_req[0] on the dispatch edge of input 0 -> irr[0] remains 1 and a second 8'h08 delivery follows EOI. Write 8'h40 instead of EOI -> irr cleared and in_service stays 1.
- Drive reset_n=0 for one edge while in_service=1 and irr=8'hF0 -> all outputs return to their reset values; subsequent pulses behave as after the first reset.

Source files
------------

// File: rtl/pic_ctrl.sv
// Eight-input interrupt controller: latches request pulses, masks, picks by fixed priority,
// and hands one interrupt at a time to the core as an irq toggle plus vector byte.
module pic_ctrl #(
    parameter logic [7:0]  VBASE     = 8'h08,
    parameter logic [15:0] PORT_CMD  = 16'h0020,
    parameter logic [15:0] PORT_MASK = 16'h00A0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  irq_req,
    input  logic [15:0] port_a,
    input  logic        port_w,
    input  logic        port_r,
    input  logic [7:0]  port_o,
    output logic [7:0]  port_i,
    output logic        port_hit,
    output logic        irq,
    output logic [7:0]  irq_vec,
    output logic        in_service,
    output logic [2:0]  isr_num
);

    // Port bus: port_w/port_r are single-cycle strobes with no back-pressure; a read
    // returns its data in port_i with port_hit=1 exactly one cycle after the strobe.
    localparam logic [7:0] CMD_EOI   = 8'h20;
    localparam logic [7:0] CMD_CLEAR = 8'h40;

    logic [7:0] irr;
    logic [7:0] mask;
    logic [7:0] eligible;
    logic [7:0] irr_next;
    logic [2:0] sel;
    logic       dispatch;
    logic       cmd_wr;
    logic       mask_wr;

    assign cmd_wr   = port_w && (port_a == PORT_CMD);
    assign mask_wr  = port_w && (port_a == PORT_MASK);
    assign eligible = irr & ~mask;
    assign dispatch = !in_service && (eligible != 8'h00);

    // Lowest set index wins, so scan from the top down and let low bits overwrite.
    always_comb begin
        sel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (eligible[i]) sel = 3'(i);
        end
    end

    // New request pulses are OR-ed in last so a same-edge set beats any clear.
    always_comb begin
        irr_next = irr;
        if (dispatch) irr_next[sel] = 1'b0;
        if (cmd_wr && port_o == CMD_CLEAR) irr_next = 8'h00;
        irr_next = irr_next | irq_req;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            irr        <= 8'h00;
            mask       <= 8'h00;
            in_service <= 1'b0;
            isr_num    <= 3'd0;
            irq        <= 1'b0;
            irq_vec    <= 8'h00;
            port_i     <= 8'h00;
            port_hit   <= 1'b0;
        end else begin
            irr <= irr_next;
            if (mask_wr) mask <= port_o;

            if (dispatch) begin
                irq        <= ~irq;
                irq_vec    <= VBASE + {5'd0, sel};
                isr_num    <= sel;
                in_service <= 1'b1;
            end else if (cmd_wr && port_o == CMD_EOI) begin
                in_service <= 1'b0;
            end

            // Reads see the register values from before any same-edge write.
            if (port_r && port_a == PORT_CMD) begin
                port_i   <= irr;
                port_hit <= 1'b1;
            end else if (port_r && port_a == PORT_MASK) begin
                port_i   <= mask;
                port_hit <= 1'b1;
            end else begin
                port_hit <= 1'b0;
            end
        end
    end

endmodule
